// File: rtl/prop_sequencer.sv
// Sequences one training sample through a DEPTH-stage perceptron chain: forward
// phase, error evaluation, backward phase, result handshake. Optional macro
// PROP_SEQ_SKIP_ZERO_ERR_EN skips the backward phase when the error mask is zero.
module prop_sequencer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 8
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_data,
    input  logic [2:0] in_target,
    output logic [2:0] chain_fin,
    output logic       fd_prop,
    input  logic [2:0] chain_fout,
    output logic [2:0] chain_bin,
    output logic       bk_prop,
    input  logic [2:0] chain_bout,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [2:0] res_out,
    output logic [2:0] res_err,
    output logic [2:0] res_bout,
    output logic       res_back,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        EVAL,
        BWD,
        DONE
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic [2:0]    fin_q, fin_d;
    logic [2:0]    target_q, target_d;
    logic [2:0]    err_q, err_d;
    logic [2:0]    res_out_q, res_out_d;
    logic [2:0]    res_bout_q, res_bout_d;
    logic          res_back_q, res_back_d;
    logic [2:0]    err_now;
    logic          accept;

    assign accept  = in_valid && in_ready_q && (state_q == IDLE);
    assign err_now = chain_fout ^ target_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        in_ready_d = 1'b0;
        fin_d      = fin_q;
        target_d   = target_q;
        err_d      = err_q;
        res_out_d  = res_out_q;
        res_bout_d = res_bout_q;
        res_back_d = res_back_q;
        case (state_q)
            IDLE: begin
                // in_ready rises one cycle after entering IDLE and falls on the accepting edge
                in_ready_d = !accept;
                if (accept) begin
                    fin_d    = in_data;
                    target_d = in_target;
                    cnt_d    = '0;
                    state_d  = FWD;
                end
            end
            FWD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = EVAL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            EVAL: begin
                res_out_d = chain_fout;
                err_d     = err_now;
                state_d   = BWD;
`ifdef PROP_SEQ_SKIP_ZERO_ERR_EN
                if (err_now == 3'b000) begin
                    res_back_d = 1'b0;
                    res_bout_d = '0;
                    state_d    = DONE;
                end
`endif
            end
            BWD: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d      = '0;
                    res_bout_d = chain_bout;
                    res_back_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            fin_q      <= '0;
            target_q   <= '0;
            err_q      <= '0;
            res_out_q  <= '0;
            res_bout_q <= '0;
            res_back_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            fin_q      <= fin_d;
            target_q   <= target_d;
            err_q      <= err_d;
            res_out_q  <= res_out_d;
            res_bout_q <= res_bout_d;
            res_back_q <= res_back_d;
        end
    end

    // Strobes come from registered state only, so reset drops them asynchronously
    assign fd_prop   = (state_q == FWD);
    assign bk_prop   = (state_q == BWD);
    assign res_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign in_ready  = in_ready_q;
    assign chain_fin = fin_q;
    assign chain_bin = err_q;
    assign res_out   = res_out_q;
    assign res_err   = err_q;
    assign res_bout  = res_bout_q;
    assign res_back  = res_back_q;

endmodule

// File: doc/prop_sequencer.md
# prop_sequencer

Training-sample sequencer that sits directly upstream of a chain of DEPTH perceptron unit stages. It accepts one 3-bit sample and its 3-bit target over a valid/ready handshake, drives the chain's first-stage input and forward-propagate strobe for DEPTH cycles, and forms the error mask from the last stage's output. It then drives the last stage's backward input and backward-propagate strobe for DEPTH cycles, and returns the result over a second valid/ready handshake.

## Interface
- DEPTH, 4, number of unit stages in the chain (1..255)
- CW, 8, width of the phase counter (must hold DEPTH-1)

- clk_in  input  1  single clock; all state on rising edge
- rst_in  input  1  asynchronous, active-low reset
- in_valid  input  1  sample offered
- in_ready  output  1  sequencer can accept a sample
- in_data  input  3  sample bits
- in_target  input  3  expected chain output
- chain_fin  output  3  held sample to first stage fin
- fd_prop  output  1  forward-propagate strobe to all stages
- chain_fout  input  3  last stage fout
- chain_bin  output  3  error mask to last stage bin
- bk_prop  output  1  backward-propagate strobe to all stages
- chain_bout  input  3  first stage bout, returned in result
- res_valid  output  1  result available
- res_ready  input  1  result consumer ready
- res_out  output  3  captured chain_fout
- res_err  output  3  captured error mask
- res_bout  output  3  captured chain_bout at end of backward phase
- res_back  output  1  1 if a backward phase ran for this sample
- busy  output  1  state is not IDLE

## Operation
- FSM states: IDLE, FWD, EVAL, BWD, DONE; one phase counter cnt (CW bits).
- IDLE: in_ready=1. When in_valid && in_ready: register in_data into chain_fin and in_target into target. Clear cnt. Go to FWD.
- FWD: fd_prop=1. cnt increments each cycle. At cnt==DEPTH-1, clear cnt and go to EVAL.
- EVAL: one cycle, no strobes. Register res_out=chain_fout and err=chain_fout^in_target (registered target). Drive chain_bin=err from the next cycle. Go to BWD, except the skip case in Configuration.
- BWD: bk_prop=1 and chain_bin held. cnt counts to DEPTH-1 as in FWD. On the last BWD cycle, register res_bout=chain_bout and res_back=1. Go to DONE.
- DONE: res_valid=1, all result fields stable. On res_ready, go to IDLE; res_valid drops the next cycle.
- Strobes are decoded from registered state only; they never depend on handshake inputs.
- Samples with in_valid while not IDLE are not accepted; the sequencer holds no queue.
- chain_fin and chain_bin change only at acceptance and at EVAL respectively.

## Timing
- Reset (rst_in low): state IDLE, cnt=0. All outputs are 0, including in_ready: it is a register set to 1 on the first clock edge after release.
- Acceptance at edge E0. fd_prop is high for exactly DEPTH consecutive cycles starting the cycle after E0. EVAL follows. bk_prop is then high for exactly DEPTH cycles.
- res_valid rises 2*DEPTH+2 cycles after E0 (DEPTH+2 when skipped).
- Earliest next acceptance: one cycle after the res_valid/res_ready handshake completes. Throughput is 1 sample per 2*DEPTH+4 cycles minimum.
- fd_prop and bk_prop are never high in the same cycle. Neither is high in IDLE, EVAL or DONE.
- Reset mid-operation: immediate abort; strobes drop asynchronously and the captured sample is discarded. The chain's own state is not touched by this block.
- DEPTH=1: each phase is a single strobe cycle; cnt never increments.

## Configuration
- PROP_SEQ_SKIP_ZERO_ERR_EN defined: if err==0 in EVAL, go directly to DONE with res_back=0, res_bout=0, chain_bin=0, and no bk_prop cycles.
- Undefined: BWD always runs; a zero mask is still propagated for DEPTH cycles and res_back is always 1.

## Test plan
- Reset: hold rst_in low 3 cycles, then release.
  - During reset all outputs are 0.
  - in_ready=1 one cycle after release; busy=0.
- Match, DEPTH=4, macro off: in_data=101, in_target=101, chain_fout=101.
  - fd_prop high for cycles 1–4, then EVAL.
  - chain_bin=000, bk_prop high for cycles 6–9.
  - res_valid at cycle 10 with res_out=101, res_err=000, res_back=1.
- Mismatch: chain_fout=110, in_target=011.
  - chain_bin=101, held through all 4 bk_prop cycles.
  - res_err=101.
  - res_bout equals chain_bout driven in the last BWD cycle (e.g. 010).
- Backpressure: hold res_ready low 5 cycles in DONE.
  - res_valid and fields stay stable; in_ready=0.
  - A concurrent in_valid is not accepted.
  - Release res_ready: IDLE, and in_ready=1 on the following cycle.
- Macro on, zero error: bk_prop never asserts and res_valid at cycle 6 with res_back=0. Mismatch case with macro on matches the off-build results.
- Reset in BWD at cnt=2: bk_prop and busy go to 0 immediately. After release, a new sample runs the full sequence from FWD.
